// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: FSM encoding, PC source select values and
// the bubble instruction loaded into IF/ID on a flush.
package fetch_ctrl_pkg;

  // Fetch sequencer states; 2'd3 is unused and recovers to ST_BOOT.
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_REQ   = 2'd1,
    ST_STALL = 2'd2
  } fetch_state_e;

  // PC mux source select.
  localparam logic PC_SEQ = 1'b0;
  localparam logic PC_BR  = 1'b1;

  // Bubble instruction written into IF/ID on a flush.
  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter with enable and synchronous clear. Holds at
// all-ones instead of wrapping; reusable for performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count register: clear wins, then increment unless already saturated.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_r <= {W{1'b0}};
    end else if (en && (count_r != {W{1'b1}})) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer. Controls PC load/select, IF/ID load/flush and
// the instruction-memory request, arbitrating branch redirects, load-use
// stalls and a variable-latency memory acknowledge. A branch that arrives
// while memory has not acknowledged is parked in a pending register and
// applied on the next acknowledge.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_branch_taken,
  input  logic [31:0]      i_branch_addr,
  input  logic             i_stall,
  input  logic             i_im_ack,
  output logic             o_im_req,
  output logic             o_pc_we,
  output logic             o_pc_sel,
  output logic [31:0]      o_redirect_addr,
  output logic             o_ifid_we,
  output logic             o_ifid_flush,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam logic [3:0] BOOT_LOAD = 4'(BOOT_CYCLES);

  fetch_state_e state_r;
  fetch_state_e state_nxt_s;
  logic [3:0]   boot_cnt_r;
  logic         pending_r;
  logic         pending_nxt_s;
  logic [31:0]  pending_addr_r;
  logic [31:0]  pending_addr_nxt_s;

  logic         redirect_s;
  logic         im_req_s;
  logic         pc_we_s;
  logic         pc_sel_s;
  logic [31:0]  redirect_addr_s;
  logic         ifid_we_s;
  logic         ifid_flush_s;
  logic         stall_cnt_en_s;

  // State, boot countdown and pending-redirect registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r        <= ST_BOOT;
      boot_cnt_r     <= BOOT_LOAD;
      pending_r      <= 1'b0;
      pending_addr_r <= NOP_INSN;
    end else begin
      state_r        <= state_nxt_s;
      pending_r      <= pending_nxt_s;
      pending_addr_r <= pending_addr_nxt_s;
      if (state_r == ST_BOOT) begin
        boot_cnt_r <= (boot_cnt_r > 4'd1) ? (boot_cnt_r - 4'd1) : boot_cnt_r;
      end else begin
        boot_cnt_r <= BOOT_LOAD;
      end
    end
  end

  // Next-state and control outputs; a parked redirect beats a fresh branch,
  // which is on the wrong path by then.
  always_comb begin
    state_nxt_s        = state_r;
    pending_nxt_s      = pending_r;
    pending_addr_nxt_s = pending_addr_r;
    redirect_s         = pending_r | i_branch_taken;
    im_req_s           = 1'b0;
    pc_we_s            = 1'b0;
    pc_sel_s           = PC_SEQ;
    ifid_we_s          = 1'b0;
    ifid_flush_s       = 1'b0;
    redirect_addr_s    = pending_r ? pending_addr_r : i_branch_addr;

    if (i_rst) begin
      redirect_s      = 1'b0;
      redirect_addr_s = 32'h0000_0000;
    end else begin
      case (state_r)
        ST_BOOT: begin
          if (boot_cnt_r <= 4'd1) begin
            state_nxt_s = ST_REQ;
          end else begin
            state_nxt_s = ST_BOOT;
          end
        end
        ST_REQ: begin
          im_req_s = 1'b1;
          if (i_im_ack) begin
            if (redirect_s) begin
              pc_we_s       = 1'b1;
              pc_sel_s      = PC_BR;
              ifid_flush_s  = 1'b1;
              pending_nxt_s = 1'b0;
            end else if (i_stall) begin
              state_nxt_s = ST_STALL;
            end else begin
              pc_we_s   = 1'b1;
              ifid_we_s = 1'b1;
            end
          end else begin
            if (i_branch_taken && !pending_r) begin
              pending_nxt_s      = 1'b1;
              pending_addr_nxt_s = i_branch_addr;
              ifid_flush_s       = 1'b1;
            end else begin
              pending_nxt_s = pending_r;
            end
          end
        end
        ST_STALL: begin
          if (redirect_s) begin
            pc_we_s       = 1'b1;
            pc_sel_s      = PC_BR;
            ifid_flush_s  = 1'b1;
            pending_nxt_s = 1'b0;
            state_nxt_s   = ST_REQ;
          end else if (i_stall) begin
            state_nxt_s = ST_STALL;
          end else begin
            pc_we_s     = 1'b1;
            ifid_we_s   = 1'b1;
            state_nxt_s = ST_REQ;
          end
        end
        default: begin
          state_nxt_s   = ST_BOOT;
          pending_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Stall accounting: every post-boot cycle in which the PC did not load.
  always_comb begin
    stall_cnt_en_s = 1'b0;
    if (!i_rst && (state_r != ST_BOOT)) begin
      stall_cnt_en_s = ~pc_we_s;
    end else begin
      stall_cnt_en_s = 1'b0;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (i_clk),
    .clr   (i_rst),
    .en    (stall_cnt_en_s),
    .count (o_stall_cnt)
  );

  assign o_im_req        = im_req_s;
  assign o_pc_we         = pc_we_s;
  assign o_pc_sel        = pc_sel_s;
  assign o_redirect_addr = redirect_addr_s;
  assign o_ifid_we       = ifid_we_s;
  assign o_ifid_flush    = ifid_flush_s;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: each driven cycle pushes its expected
// outputs; a monitor pops and compares them late in the same cycle. A second
// instance with a 4-bit counter shares the stimulus to show saturation.
module tb_fetch_ctrl;

  localparam logic [4:0] C_ZERO = 5'b00000; // {req,pc_we,pc_sel,ifid_we,flush}
  localparam logic [4:0] C_ADV  = 5'b11010;
  localparam logic [4:0] C_RED  = 5'b11101;
  localparam logic [4:0] C_SREQ = 5'b10000;
  localparam logic [4:0] C_STL  = 5'b00000;
  localparam logic [4:0] C_REL  = 5'b01010;
  localparam logic [4:0] C_REDS = 5'b01101;
  localparam logic [4:0] C_NBR  = 5'b10001;

  typedef struct {
    logic [4:0]  ctl;
    logic [31:0] raddr;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        br;
  logic [31:0] br_addr;
  logic        stall;
  logic        ack;

  logic        im_req, pc_we, pc_sel, ifid_we, ifid_flush;
  logic [31:0] raddr;
  logic [15:0] stall_cnt;
  logic        im_req4, pc_we4, pc_sel4, ifid_we4, ifid_flush4;
  logic [31:0] raddr4;
  logic [3:0]  stall_cnt4;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] cnt_m    = 16'd0;
  logic [3:0]  cnt4_m   = 4'd0;

  fetch_ctrl #(.BOOT_CYCLES(2), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_branch_taken(br), .i_branch_addr(br_addr),
    .i_stall(stall), .i_im_ack(ack), .o_im_req(im_req), .o_pc_we(pc_we),
    .o_pc_sel(pc_sel), .o_redirect_addr(raddr), .o_ifid_we(ifid_we),
    .o_ifid_flush(ifid_flush), .o_stall_cnt(stall_cnt)
  );

  fetch_ctrl #(.BOOT_CYCLES(2), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_branch_taken(br), .i_branch_addr(br_addr),
    .i_stall(stall), .i_im_ack(ack), .o_im_req(im_req4), .o_pc_we(pc_we4),
    .o_pc_sel(pc_sel4), .o_redirect_addr(raddr4), .o_ifid_we(ifid_we4),
    .o_ifid_flush(ifid_flush4), .o_stall_cnt(stall_cnt4)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One stimulus cycle: drive inputs, push expectation, advance counter model.
  task automatic cyc(input logic r, input logic b, input logic [31:0] a,
                     input logic s, input logic k, input logic boot,
                     input logic [4:0] ctl, input logic [31:0] ra);
    exp_t e;
    @(negedge clk);
    #1;
    rst = r; br = b; br_addr = a; stall = s; ack = k;
    e.ctl = ctl; e.raddr = ra; e.cnt = cnt_m; e.cnt4 = cnt4_m;
    sb_q.push_back(e);
    if (r) begin
      cnt_m  = 16'd0;
      cnt4_m = 4'd0;
    end else if (!boot && !ctl[3]) begin
      if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
      if (cnt4_m != 4'hF) cnt4_m = cnt4_m + 4'd1;
    end
  endtask

  // Monitor: compare late in the cycle, well before the next rising edge.
  always begin
    exp_t e;
    @(negedge clk);
    #4;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq("ctl",   {27'd0, im_req, pc_we, pc_sel, ifid_we, ifid_flush}, {27'd0, e.ctl});
      check_eq("raddr", raddr, e.raddr);
      check_eq("cnt",   {16'd0, stall_cnt}, {16'd0, e.cnt});
      check_eq("cnt4",  {28'd0, stall_cnt4}, {28'd0, e.cnt4});
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; br = 1'b0; br_addr = 32'd0; stall = 1'b0; ack = 1'b0;
    // Reset, boot delay, then one instruction per cycle.
    repeat (2) cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, C_ZERO, 32'd0);
    repeat (2) cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, C_ZERO, 32'd0);
    repeat (4) cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, C_ADV, 32'd0);
    // Redirect with ack high.
    cyc(1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 1'b0, C_RED, 32'h40);
    cyc(1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 1'b0, C_ADV, 32'd0);
    // Three-cycle load-use stall, then release.
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, C_SREQ, 32'd0);
    repeat (2) cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, C_STL, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, C_REL, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, C_ADV, 32'd0);
    // Branch parked while ack low; later branch ignored.
    cyc(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, C_NBR,  32'h100);
    cyc(1'b0, 1'b0, 32'd0,   1'b0, 1'b0, 1'b0, C_SREQ, 32'h100);
    cyc(1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, C_SREQ, 32'h100);
    cyc(1'b0, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, C_RED,  32'h100);
    cyc(1'b0, 1'b0, 32'd0,   1'b0, 1'b1, 1'b0, C_ADV,  32'd0);
    // Branch during STALL with stall still high.
    cyc(1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b0, C_SREQ, 32'd0);
    cyc(1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 1'b0, C_REDS, 32'h80);
    cyc(1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 1'b0, C_ADV,  32'd0);
    // Reset mid-STALL; branch in BOOT ignored.
    cyc(1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b0, C_SREQ, 32'd0);
    cyc(1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b0, C_STL,  32'd0);
    cyc(1'b1, 1'b1, 32'h55, 1'b1, 1'b1, 1'b0, C_ZERO, 32'd0);
    cyc(1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 1'b1, C_ZERO, 32'd0);
    cyc(1'b0, 1'b1, 32'h44, 1'b0, 1'b1, 1'b1, C_ZERO, 32'h44);
    cyc(1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 1'b0, C_ADV,  32'd0);
    // Reset with a redirect pending: it must be discarded.
    cyc(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, C_NBR,  32'h300);
    cyc(1'b1, 1'b0, 32'd0,   1'b0, 1'b0, 1'b0, C_ZERO, 32'd0);
    repeat (2) cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, C_ZERO, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, C_ADV, 32'd0);
    // Long held stall: 4-bit counter saturates at 15.
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, C_SREQ, 32'd0);
    repeat (19) cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, C_STL, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, C_REL, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, C_ADV, 32'd0);
    @(negedge clk);
    #6;
    check_eq("drain", sb_q.size(), 32'd0);
    check_eq("sat15", {28'd0, stall_cnt4}, 32'd15);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
